frame_writer: RTL
=================

FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 Parameter COOR_WIDTH, default 11, sets the width of the pixel coordinates.
REQ-002 Parameter FRAME_WIDTH, default 800, is the visible columns per buffer.
REQ-003 Parameter FRAME_HEIGHT, default 480, is the visible rows per buffer.
REQ-004 Parameter ADDR_WIDTH, default 19, is the per-buffer pixel address width (FRAME_WIDTH*FRAME_HEIGHT <= 2**ADDR_WIDTH).
REQ-005 clk_33m  input  1  is the single clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  is the reset, synchronous and active-high.
REQ-007 pix_valid  input  1  qualifies the pixel on pix_x/pix_y/pix_palette this cycle.
REQ-008 pix_x, pix_y  input  COOR_WIDTH each  are the pixel frame coordinates from the painter.
REQ-009 pix_palette  input  2  is the pixel palette index.
REQ-010 frame_done  input  1  is a one-cycle pulse: the painter has emitted its last pixel of the frame.
REQ-011 vsync  input  1  is a one-cycle pulse at the start of display vertical blank.
REQ-012 paint_start  output  1  is a one-cycle pulse that restarts the painter (drives its rst).
REQ-013 mem_we  output  1  is the framebuffer write enable.
REQ-014 mem_addr  output  ADDR_WIDTH+1  is {back buffer bit, y*FRAME_WIDTH+x}.
REQ-015 mem_data  output  2  is the palette written.
REQ-016 front_buf  output  1  is the buffer the display reader scans.
REQ-017 missed_vsync  output  8  is a saturating count of vsyncs that arrive while painting.

Function
REQ-018 Back buffer SHALL always be ~front_buf.
REQ-019 Pixel pipeline SHALL be 2 stages: stage 1 registers the inputs and computes the in-bounds check; stage 2 registers mem_we/mem_addr/mem_data; latency is exactly 2 cycles from input to mem_we.
REQ-020 A pixel SHALL be written only if pix_valid, pix_x < FRAME_WIDTH, pix_y < FRAME_HEIGHT, and the FSM is in PAINT when the pixel is sampled; otherwise it SHALL be dropped silently.
REQ-021 The address multiply SHALL be by the constant FRAME_WIDTH, computed without truncation before it is sliced to ADDR_WIDTH.
REQ-022 mem_addr MSB SHALL be the back-buffer bit at stage-1 sample time.
REQ-023 FSM states: START, PAINT, FLUSH, WAIT_VSYNC.
REQ-024 START: assert paint_start for exactly one cycle, then go to PAINT.
REQ-025 PAINT: accept pixels; on frame_done go to FLUSH.
REQ-026 PAINT: each vsync increments missed_vsync, saturating at 255; the front buffer is unchanged.
REQ-027 FLUSH: hold 2 cycles so that in-flight pixels commit, then go to WAIT_VSYNC; a vsync during FLUSH SHALL be latched as pending.
REQ-028 WAIT_VSYNC: on vsync or pending, toggle front_buf, clear pending, and go to START in the same cycle.
REQ-029 frame_done and vsync in the same PAINT cycle: enter FLUSH and also count the vsync as missed.
REQ-030 frame_done outside PAINT SHALL be ignored.
REQ-031 No framebuffer write SHALL target the front buffer.

Reset
REQ-032 On rst: state=START, front_buf=0, pending=0, missed_vsync=0, both pipeline valid bits=0, mem_we=0, mem_addr=0, mem_data=0, paint_start=0.
REQ-033 rst mid-frame SHALL discard in-flight pixels; the first cycle after rst de-asserts is START.

Structure
REQ-034 FRAME_WIDTH, FRAME_HEIGHT, ADDR_WIDTH, COOR_WIDTH defaults and the FSM state enum SHALL live in shared package render_pkg.
REQ-035 The 2-stage pixel pipeline SHALL be sub-module pixel_addr_pipe; the FSM and counters stay in frame_writer.

Verification
REQ-036 Reset release -> paint_start is high on exactly the 1st cycle, front_buf=0, mem_we=0.
REQ-037 Pixel (x=10, y=2, pal=3, valid) in PAINT -> 2 cycles later mem_we=1, mem_addr={1,1610}, mem_data=3.
REQ-038 Pixels x=800 (y=0) and y=480 (x=0), plus a pixel with valid=0 -> mem_we stays 0.
REQ-039 frame_done, then vsync 1 cycle later (during FLUSH) -> front_buf toggles to 1 when FLUSH ends, paint_start pulses the next cycle, and later writes have MSB=0.
REQ-040 300 vsyncs during PAINT -> missed_vsync=255 and front_buf unchanged.
REQ-041 rst asserted with a pixel in stage 1 -> no mem_we after reset, and state restarts at START.

Source files
------------

// File: rtl/render_pkg.sv
// Shared defaults and FSM state type for the frame rendering path.
package render_pkg;

  localparam int unsigned DefCoorWidth   = 11;
  localparam int unsigned DefFrameWidth  = 800;
  localparam int unsigned DefFrameHeight = 480;
  localparam int unsigned DefAddrWidth   = 19;

  typedef enum logic [1:0] {
    StStart,
    StPaint,
    StFlush,
    StWaitVsync
  } fw_state_e;

endpackage

// File: rtl/pixel_addr_pipe.sv
// Two-stage pixel pipeline: stage 1 captures and bounds-checks the pixel,
// stage 2 presents the linear framebuffer write.
module pixel_addr_pipe
  import render_pkg::*;
#(
  parameter int unsigned COOR_WIDTH   = DefCoorWidth,
  parameter int unsigned FRAME_WIDTH  = DefFrameWidth,
  parameter int unsigned FRAME_HEIGHT = DefFrameHeight,
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth
) (
  input  logic                  clk_33m,
  input  logic                  rst,
  input  logic                  accept,
  input  logic                  back_buf,
  input  logic                  pix_valid,
  input  logic [COOR_WIDTH-1:0] pix_x,
  input  logic [COOR_WIDTH-1:0] pix_y,
  input  logic [1:0]            pix_palette,
  output logic                  mem_we,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic [1:0]            mem_data
);

  // Product width wide enough that y*FRAME_WIDTH+x never truncates before slicing.
  localparam int unsigned MulW = COOR_WIDTH + $clog2(FRAME_WIDTH + 1) + 1;

  logic                  in_bounds;
  logic                  s1_valid_q;
  logic [COOR_WIDTH-1:0] s1_x_q;
  logic [COOR_WIDTH-1:0] s1_y_q;
  logic [1:0]            s1_pal_q;
  logic                  s1_buf_q;
  logic [MulW-1:0]       lin_addr;
  logic                  unused_addr_hi;

  assign in_bounds = (32'(pix_x) < FRAME_WIDTH) && (32'(pix_y) < FRAME_HEIGHT);
  assign lin_addr  = MulW'(s1_y_q) * MulW'(FRAME_WIDTH) + MulW'(s1_x_q);
  // In-bounds pixels never reach these bits; kept only to make that explicit.
  assign unused_addr_hi = ^lin_addr[MulW-1:ADDR_WIDTH];

  // Stage 1: capture pixel, qualify with bounds and FSM accept, latch back buffer.
  always_ff @(posedge clk_33m) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_pal_q   <= '0;
      s1_buf_q   <= 1'b0;
    end else begin
      s1_valid_q <= pix_valid && accept && in_bounds;
      s1_x_q     <= pix_x;
      s1_y_q     <= pix_y;
      s1_pal_q   <= pix_palette;
      s1_buf_q   <= back_buf;
    end
  end

  // Stage 2: register the framebuffer write.
  always_ff @(posedge clk_33m) begin
    if (rst) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      mem_we   <= s1_valid_q;
      mem_addr <= {s1_buf_q, lin_addr[ADDR_WIDTH-1:0]};
      mem_data <= s1_pal_q;
    end
  end

endmodule

// File: rtl/frame_writer.sv
// Double-buffered frame writer: sequences the painter, swaps buffers on vsync
// once a frame has fully committed, and counts vsyncs missed while painting.
module frame_writer
  import render_pkg::*;
#(
  parameter int unsigned COOR_WIDTH   = DefCoorWidth,
  parameter int unsigned FRAME_WIDTH  = DefFrameWidth,
  parameter int unsigned FRAME_HEIGHT = DefFrameHeight,
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth
) (
  input  logic                  clk_33m,
  input  logic                  rst,
  input  logic                  pix_valid,
  input  logic [COOR_WIDTH-1:0] pix_x,
  input  logic [COOR_WIDTH-1:0] pix_y,
  input  logic [1:0]            pix_palette,
  input  logic                  frame_done,
  input  logic                  vsync,
  output logic                  paint_start,
  output logic                  mem_we,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic [1:0]            mem_data,
  output logic                  front_buf,
  output logic [7:0]            missed_vsync
);

  fw_state_e state_q, state_d;
  logic      flush_cnt_q;
  logic      pending_q;
  logic      accept;
  logic      swap;

  // State register.
  always_ff @(posedge clk_33m) begin
    if (rst) state_q <= StStart;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStart:     state_d = StPaint;
      StPaint:     if (frame_done) state_d = StFlush;
      StFlush:     if (flush_cnt_q) state_d = StWaitVsync;
      StWaitVsync: if (vsync || pending_q) state_d = StStart;
      default:     state_d = StStart;
    endcase
  end

  // FSM outputs; paint_start is held low while reset is asserted.
  always_comb begin
    paint_start = (state_q == StStart) && !rst;
    accept      = (state_q == StPaint);
    swap        = (state_q == StWaitVsync) && (vsync || pending_q);
  end

  // Flush timer, pending vsync, missed-vsync counter and front buffer select.
  always_ff @(posedge clk_33m) begin
    if (rst) begin
      flush_cnt_q  <= 1'b0;
      pending_q    <= 1'b0;
      missed_vsync <= 8'd0;
      front_buf    <= 1'b0;
    end else begin
      flush_cnt_q <= (state_q == StFlush) ? ~flush_cnt_q : 1'b0;
      if (state_q == StPaint && vsync && missed_vsync != 8'hFF) begin
        missed_vsync <= missed_vsync + 8'd1;
      end
      if (state_q == StFlush && vsync) pending_q <= 1'b1;
      else if (swap)                   pending_q <= 1'b0;
      if (swap) front_buf <= ~front_buf;
    end
  end

  pixel_addr_pipe #(
    .COOR_WIDTH  (COOR_WIDTH),
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_pipe (
    .clk_33m    (clk_33m),
    .rst        (rst),
    .accept     (accept),
    .back_buf   (~front_buf),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_palette(pix_palette),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

endmodule
